// File: rtl/pulse_to_level_pkg.sv
// Shared types and defaults for the pulse_to_level stretcher.
// Imported by the FSM top and by the down_counter sub-module.
package pulse_to_level_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : pulse_to_level_pkg

// File: rtl/pulse_to_level_down_counter.sv
// Loadable down-counter that saturates at 1, so a hold never wraps.
// Clears to zero on synchronous active-low reset.
module down_counter
    import pulse_to_level_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] value,
    output logic             is_one
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // NOTE: count_d gets its default first so no path through this block can infer a latch.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (dec && (count_q > WIDTH'(1))) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments; the reset is sampled on the clock edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign value  = count_q;
    assign is_one = (count_q == WIDTH'(1));

endmodule : down_counter

// File: rtl/pulse_to_level.sv
// Stretches a trigger pulse into a registered level lasting max(len,1) cycles.
// Define PULSE_TO_LEVEL_RETRIGGER_EN to let a trigger during a hold reload it.
module pulse_to_level
    import pulse_to_level_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pulse,
    input  logic [WIDTH-1:0] len,
    output logic             level,
    output logic             done,
    output logic             overrun
);

    state_t state_q;
    state_t state_d;

    logic level_q;
    logic level_d;
    logic done_q;
    logic done_d;
    logic overrun_q;
    logic overrun_d;

    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_is_one;
    logic [WIDTH-1:0] cnt_value;
    logic [WIDTH-1:0] hold_len;

    // A zero length still produces a one-cycle level.
    assign hold_len = (len == '0) ? WIDTH'(1) : len;

    down_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (hold_len),
        .dec        (cnt_dec),
        .value      (cnt_value),
        .is_one     (cnt_is_one)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pulse) begin
                    state_d  = HOLD;
                    cnt_load = 1'b1;
                end
            end
            HOLD: begin
`ifdef PULSE_TO_LEVEL_RETRIGGER_EN
                if (pulse) begin
                    cnt_load = 1'b1;
                end else if (cnt_is_one || (cnt_value == '0)) begin
                    state_d = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
`else
                // Exiting on a zero count too keeps a corrupted counter from hanging the hold.
                if (cnt_is_one || (cnt_value == '0)) begin
                    state_d = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
`endif
            end
            DONE: begin
                if (pulse) begin
                    state_d  = HOLD;
                    cnt_load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they come straight out of flops.
        level_d   = (state_d == HOLD);
        done_d    = (state_d == DONE);
        overrun_d = (state_q == HOLD) && pulse;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            level_q   <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign level   = level_q;
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule : pulse_to_level

// File: tb/tb_pulse_to_level.sv
// Self-checking bench for pulse_to_level: directed scenarios plus random traffic
// checked against a cycle-count reference model.
module tb_pulse_to_level;

    localparam int WIDTH = 8;
`ifdef PULSE_TO_LEVEL_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             pulse = 1'b0;
    logic [WIDTH-1:0] len   = '0;
    logic             level;
    logic             done;
    logic             overrun;

    int errors = 0;
    int checks = 0;

    // Reference model: number of high cycles still owed, plus the expected outputs.
    int   m_left  = 0;
    logic m_level = 1'b0;
    logic m_done  = 1'b0;
    logic m_over  = 1'b0;

    pulse_to_level #(
        .WIDTH (WIDTH)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .pulse   (pulse),
        .len     (len),
        .level   (level),
        .done    (done),
        .overrun (overrun)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Drive one cycle of inputs, advance the model at the edge, return at the falling edge.
    task automatic tick(input logic p, input logic [WIDTH-1:0] l, input logic r);
        int n;
        pulse = p;
        len   = l;
        reset = r;
        @(posedge clock);
        n = (l == '0) ? 1 : int'(l);
        if (!r) begin
            m_left = 0;
            m_done = 1'b0;
            m_over = 1'b0;
        end else begin
            m_over = m_level && p;
            if (m_level) begin
                if (p && RETRIG) m_left = n;
                else             m_left = m_left - 1;
                m_done = (m_left == 0);
            end else begin
                m_done = 1'b0;
                if (p) m_left = n;
            end
        end
        m_level = (m_left > 0);
        @(negedge clock);
    endtask

    task automatic settle();
        for (int i = 0; i < 300 && (m_level || m_done); i++) tick(1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 8'd5, 1'b0);
            checks++;
            if ({level, done, overrun} !== 3'b000) begin
                errors++;
                $display("FAIL reset cycle %0d: level/done/overrun=%b%b%b expected 000",
                         i, level, done, overrun);
            end
        end
    endtask

    task automatic test_basic();
        logic exp_l, exp_d;
        settle();
        tick(1'b1, 8'd5, 1'b1);
        for (int c = 11; c <= 18; c++) begin
            exp_l = (c >= 11) && (c <= 15);
            exp_d = (c == 16);
            checks++;
            if (level !== exp_l || done !== exp_d || overrun !== 1'b0) begin
                errors++;
                $display("FAIL basic cycle %0d: level/done/overrun=%b%b%b expected %b%b0",
                         c, level, done, overrun, exp_l, exp_d);
            end
            // len wanders during the hold and must not disturb it
            tick(1'b0, WIDTH'($urandom_range(0, 255)), 1'b1);
        end
    endtask

    task automatic test_zero_len();
        settle();
        tick(1'b1, 8'd0, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (level !== (c == 1) || done !== (c == 2)) begin
                errors++;
                $display("FAIL zero_len cycle %0d: level=%b done=%b expected level=%b done=%b",
                         c, level, done, (c == 1), (c == 2));
            end
            tick(1'b0, 8'd0, 1'b1);
        end
    endtask

    task automatic test_overrun();
        logic exp_l, exp_d, exp_o;
        settle();
        tick(1'b1, 8'd4, 1'b1);
        tick(1'b0, 8'd4, 1'b1);
        checks++;
        if (level !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun cycle 12: level=%b overrun=%b expected level=1 overrun=0",
                     level, overrun);
        end
        tick(1'b1, 8'd4, 1'b1);
        for (int c = 13; c <= 18; c++) begin
            exp_l = RETRIG ? (c <= 16) : (c <= 14);
            exp_d = RETRIG ? (c == 17) : (c == 15);
            exp_o = (c == 13);
            checks++;
            if ({level, done, overrun} !== {exp_l, exp_d, exp_o}) begin
                errors++;
                $display("FAIL overrun cycle %0d: level/done/overrun=%b%b%b expected %b%b%b",
                         c, level, done, overrun, exp_l, exp_d, exp_o);
            end
            tick(1'b0, 8'd4, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        settle();
        tick(1'b1, 8'd3, 1'b1);
        tick(1'b0, 8'd3, 1'b1);
        tick(1'b0, 8'd3, 1'b1);
        tick(1'b0, 8'd3, 1'b1);
        pulse = 1'b1;
        #1;
        checks++;
        if (done !== 1'b1 || level !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back done cycle: done=%b level=%b expected done=1 level=0",
                     done, level);
        end
        tick(1'b1, 8'd3, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (level !== (c <= 3) || done !== (c == 4) || overrun !== 1'b0) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: level/done/overrun=%b%b%b expected %b%b0",
                         c, level, done, overrun, (c <= 3), (c == 4));
            end
            tick(1'b0, 8'd3, 1'b1);
        end
    endtask

    task automatic test_mid_hold_reset();
        int cnt;
        logic saw_done;
        settle();
        tick(1'b1, 8'd200, 1'b1);
        for (int i = 0; i < 49; i++) tick(1'b0, 8'd200, 1'b1);
        checks++;
        if (level !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset hold cycle 50: level=%b expected 1", level);
        end
        tick(1'b0, 8'd200, 1'b0);
        checks++;
        if ({level, done, overrun} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset after reset: level/done/overrun=%b%b%b expected 000",
                     level, done, overrun);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 8'd200, 1'b1);
            if (done !== 1'b0 || level !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL mid_reset quiet: saw done/level after reset, expected none");
        end
        tick(1'b1, 8'd200, 1'b1);
        cnt = 0;
        while (level === 1'b1 && cnt < 300) begin
            cnt++;
            tick(1'b0, WIDTH'($urandom_range(0, 255)), 1'b1);
        end
        checks++;
        if (cnt != 200 || done !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset rehold: high for %0d cycles done=%b expected 200 cycles done=1",
                     cnt, done);
        end
    endtask

    task automatic test_random();
        logic p, r;
        logic [WIDTH-1:0] l;
        settle();
        for (int i = 0; i < 3000; i++) begin
            p = ($urandom_range(0, 4) == 0);
            r = ($urandom_range(0, 149) != 0);
            l = ($urandom_range(0, 9) == 0) ? WIDTH'($urandom_range(0, 255))
                                             : WIDTH'($urandom_range(0, 6));
            tick(p, l, r);
            checks++;
            if ({level, done, overrun} !== {m_level, m_done, m_over}) begin
                errors++;
                $display("FAIL random step %0d: level/done/overrun=%b%b%b expected %b%b%b",
                         i, level, done, overrun, m_level, m_done, m_over);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_overrun();
        test_back_to_back();
        test_mid_hold_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pulse_to_level
